// File: rtl/auth_msg_serializer.sv
// Byte-wide serializer for authentication response messages: captures header+payload
// on a rising msg_ack, streams it MSB-first over valid/ready with sof/eof framing.
module auth_msg_serializer #(
  parameter int unsigned HDR_BYTES = 4,
  parameter int unsigned PLD_BYTES = 12
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   msg_ack,
  input  logic [8*HDR_BYTES-1:0] header,
  input  logic [8*PLD_BYTES-1:0] payload,
  input  logic                   tx_ready,
  input  logic                   clr_ovr,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   tx_sof,
  output logic                   tx_eof,
  output logic                   busy,
  output logic                   done,
  output logic                   ovr
);

  localparam int unsigned TOTAL = HDR_BYTES + PLD_BYTES;
  localparam int unsigned MSG_W = 8 * TOTAL;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             ack_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MSG_W-1:0] buf_q, buf_d;
  logic             ovr_q, ovr_d;
  logic             start;

  // Only the 0->1 transition of the level acknowledge starts a message.
  assign start = msg_ack & ~ack_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    ovr_d    = ovr_q;
    tx_valid = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = {header, payload};
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          // The head byte is always the one on the wire, so a stall leaves tx_data untouched.
          buf_d = {buf_q[MSG_W-9:0], 8'h00};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A message edge while one is in flight is dropped and flagged; set beats clear.
    if (clr_ovr) ovr_d = 1'b0;
    if (start && (state_q != S_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      // NOTE: the buffer is a plain register bank (not a RAM), so resetting it is cheap
      // and keeps tx_data at 0 while in reset.
      buf_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ack_q   <= msg_ack;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tx_data = buf_q[MSG_W-1 -: 8];
  assign tx_sof  = tx_valid & (cnt_q == '0);
  assign tx_eof  = tx_valid & (cnt_q == LAST_IDX);
  assign busy    = (state_q != S_IDLE);
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_auth_msg_serializer.sv
// Scoreboard bench for auth_msg_serializer: the stimulus side pushes expected beats,
// a negedge monitor pops and compares every accepted byte plus stall, done and flag behaviour.
module tb_auth_msg_serializer;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned PLD_BYTES = 12;
  localparam int unsigned TOTAL     = HDR_BYTES + PLD_BYTES;
  localparam int unsigned MSG_W     = 8 * TOTAL;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  logic                   clk;
  logic                   reset_L;
  logic                   msg_ack;
  logic [8*HDR_BYTES-1:0] header;
  logic [8*PLD_BYTES-1:0] payload;
  logic                   tx_ready;
  logic                   clr_ovr;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_sof;
  logic                   tx_eof;
  logic                   busy;
  logic                   done;
  logic                   ovr;

  int    checks   = 0;
  int    failures = 0;
  beat_t sb_q[$];

  auth_msg_serializer #(
    .HDR_BYTES(HDR_BYTES),
    .PLD_BYTES(PLD_BYTES)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .msg_ack (msg_ack),
    .header  (header),
    .payload (payload),
    .tx_ready(tx_ready),
    .clr_ovr (clr_ovr),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_sof  (tx_sof),
    .tx_eof  (tx_eof),
    .busy    (busy),
    .done    (done),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a message is the concatenation header||payload read out in bytes,
  // most significant first, with sof on the first and eof on the last.
  task automatic push_msg(input logic [8*HDR_BYTES-1:0] h, input logic [8*PLD_BYTES-1:0] p);
    logic [MSG_W-1:0] m;
    beat_t b;
    m = {h, p};
    for (int k = 0; k < int'(TOTAL); k++) begin
      b.data = 8'((m >> (8 * (int'(TOTAL) - 1 - k))) & {{(MSG_W-8){1'b0}}, 8'hFF});
      b.sof  = (k == 0);
      b.eof  = (k == int'(TOTAL) - 1);
      sb_q.push_back(b);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic  prev_stall = 1'b0;
  beat_t prev_b;
  logic  done_exp = 1'b0;
  always @(negedge clk) begin
    beat_t cur, exp_b;
    logic  popped_eof;
    if (!reset_L) begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end else begin
      cur        = '{data: tx_data, sof: tx_sof, eof: tx_eof};
      popped_eof = 1'b0;
      check("done_pulse", done, done_exp);
      if (prev_stall) begin
        check("stall_valid_held", tx_valid, 1'b1);
        check("stall_beat_stable", cur, prev_b);
      end
      if (!tx_valid) check("idle_sof_eof", {tx_sof, tx_eof}, 2'b00);
      if (tx_valid && tx_ready) begin
        check("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          check("beat", cur, exp_b);
          popped_eof = exp_b.eof;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_b     = cur;
      done_exp   = popped_eof;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive tx_ready (0: always 1, 1: toggle starting at 1, 2: random) until the block goes idle.
  task automatic drain(input int mode, output int n_valid, output int n_busy);
    int   guard;
    logic tog;
    n_valid = 0;
    n_busy  = 0;
    guard   = 0;
    tog     = 1'b1;
    while (busy && guard < 300) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       begin tx_ready = tog; tog = ~tog; end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid) n_valid++;
      n_busy++;
      step();
      guard++;
    end
    check("drain_within_bound", guard < 300, 1'b1);
    tx_ready = 1'b0;
  endtask

  task automatic issue(input logic [8*HDR_BYTES-1:0] h, input logic [8*PLD_BYTES-1:0] p,
                       input bit accept);
    header  = h;
    payload = p;
    msg_ack = 1'b1;
    if (accept) push_msg(h, p);
  endtask

  function automatic logic [8*PLD_BYTES-1:0] rand_pld();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] BASIC_HDR = 32'h1081_01FF;
  localparam logic [95:0] BASIC_PLD = {32'h04568787, 32'hAC786425, 32'h0F986550};

  initial begin
    int nv, nb;
    reset_L  = 1'b0;
    msg_ack  = 1'b0;
    header   = '0;
    payload  = '0;
    tx_ready = 1'b0;
    clr_ovr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_sof_eof", {tx_sof, tx_eof}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovr", ovr, 1'b0);

    // msg_ack already high when reset releases: the first edge starts a message.
    issue($urandom, rand_pld(), 1'b1);
    step();
    reset_L = 1'b1;
    step();
    check("ack_at_reset_busy", busy, 1'b1);
    check("ack_at_reset_sof", tx_sof, 1'b1);
    msg_ack = 1'b0;
    drain(2, nv, nb);
    step();

    // Basic message with the sink always ready.
    issue(BASIC_HDR, BASIC_PLD, 1'b1);
    step();
    msg_ack = 1'b0;
    header  = ~BASIC_HDR;
    payload = ~BASIC_PLD;
    check("basic_first_byte", tx_data, 8'h10);
    drain(0, nv, nb);
    check("basic_valid_cycles", nv, 16);
    check("basic_busy_cycles", nb, 17);
    check("basic_ovr", ovr, 1'b0);
    step();

    // Backpressure: ready toggles 1/0 each cycle.
    issue(BASIC_HDR, BASIC_PLD, 1'b1);
    step();
    msg_ack = 1'b0;
    drain(1, nv, nb);
    check("bp_valid_cycles", nv, 31);
    step();

    // Held acknowledge: one message only over 40 high cycles.
    issue($urandom, rand_pld(), 1'b1);
    step();
    drain(0, nv, nb);
    repeat (40 - 1 - nb) begin
      step();
      check("held_ack_idle", busy, 1'b0);
    end
    msg_ack = 1'b0;
    check("held_ack_ovr", ovr, 1'b0);
    step();

    // Overrun during byte 5: second message dropped, first intact.
    issue(BASIC_HDR, BASIC_PLD, 1'b1);
    step();
    msg_ack  = 1'b0;
    tx_ready = 1'b1;
    repeat (5) step();
    issue($urandom, rand_pld(), 1'b0);
    step();
    msg_ack = 1'b0;
    check("ovr_set", ovr, 1'b1);
    drain(0, nv, nb);
    check("ovr_first_msg_len", nv, 16 - 6);
    check("ovr_sticky", ovr, 1'b1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr_cleared", ovr, 1'b0);
    repeat (3) step();
    check("ovr_second_not_sent", busy, 1'b0);

    // Edge landing in the DONE cycle together with clr_ovr: dropped, set wins.
    issue($urandom, rand_pld(), 1'b1);
    step();
    msg_ack  = 1'b0;
    tx_ready = 1'b1;
    repeat (16) step();
    check("done_cycle_reached", done, 1'b1);
    issue($urandom, rand_pld(), 1'b0);
    clr_ovr = 1'b1;
    step();
    msg_ack = 1'b0;
    clr_ovr = 1'b0;
    check("done_edge_ovr_set_wins", ovr, 1'b1);
    check("done_edge_dropped", busy, 1'b0);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("done_edge_ovr_clear", ovr, 1'b0);

    // Reset mid-stream at byte 8.
    issue(BASIC_HDR, BASIC_PLD, 1'b1);
    step();
    msg_ack  = 1'b0;
    tx_ready = 1'b1;
    repeat (8) step();
    check("pre_reset_byte8", tx_data, 8'hAC);
    reset_L = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    sb_q.delete();
    step();
    reset_L = 1'b1;
    step();
    issue($urandom, rand_pld(), 1'b1);
    step();
    msg_ack = 1'b0;
    check("post_rst_sof", tx_sof, 1'b1);
    drain(2, nv, nb);

    // Back-to-back: new edge on the first IDLE cycle after done.
    issue($urandom, rand_pld(), 1'b1);
    step();
    msg_ack = 1'b0;
    drain(0, nv, nb);
    issue($urandom, rand_pld(), 1'b1);
    step();
    msg_ack = 1'b0;
    check("b2b_accepted", {busy, tx_valid, tx_sof}, 3'b111);
    drain(2, nv, nb);
    check("b2b_ovr", ovr, 1'b0);

    // Random messages, random backpressure, inputs scrambled after capture.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) step();
      issue($urandom, rand_pld(), 1'b1);
      step();
      msg_ack = 1'b0;
      header  = $urandom;
      payload = rand_pld();
      drain(2, nv, nb);
      check("rand_valid_min", nv >= 16, 1'b1);
    end

    repeat (3) step();
    check("sb_drained", sb_q.size(), 0);
    check("final_ovr", ovr, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/auth_msg_serializer.md
# auth_msg_serializer

Byte-wide transmit serializer for authentication response messages. It sits directly downstream of the response builders (GET_DIGESTS answer and siblings). It captures a parallel header + payload when the builder raises its acknowledge, then streams the message out one byte per accepted transfer on a valid/ready interface toward the USB PD transport. It frames each message with start/end markers and flags any message lost because it arrived while a previous one was still in flight.

## Interface
Parameters:
- HDR_BYTES, 4, header length in bytes; equals `SIZE_OF_HEADER_IN_BYTES.
- PLD_BYTES, 12, payload length in bytes; equals (`MSG_LEN − 8·HDR_BYTES)/8.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- msg_ack  in  1  builder acknowledge (level); its 0→1 transition marks a new message.
- header  in  8·HDR_BYTES  header bits; MSB byte = protocol version, sent first.
- payload  in  8·PLD_BYTES  payload bits; MSB byte sent first.
- tx_ready  in  1  sink can accept a byte this cycle.
- clr_ovr  in  1  synchronous clear of ovr.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_sof  out  1  qualifies the first byte (header byte 0).
- tx_eof  out  1  qualifies the last byte (payload byte PLD_BYTES−1).
- busy  out  1  a message is held or being sent.
- done  out  1  one-cycle pulse after the last byte is accepted.
- ovr  out  1  sticky: a message edge was seen while busy.

## Operation
- Edge detect: register msg_ack as ack_q every cycle in every state. Define start = msg_ack & ~ack_q. A level held high never retriggers.
- States:
  - IDLE: on start, latch {header, payload} into the shift buffer, clear the byte counter and go to SEND.
  - SEND:
    - Present byte[cnt], counting from the MSB. tx_valid=1.
    - A transfer occurs when tx_valid & tx_ready. On a transfer, cnt += 1.
    - A transfer with cnt = HDR_BYTES+PLD_BYTES−1 goes to DONE.
  - DONE: done=1 for one cycle, tx_valid=0, then go to IDLE unconditionally.
- tx_sof = tx_valid & (cnt==0). tx_eof = tx_valid & (cnt==HDR_BYTES+PLD_BYTES−1).
- The counter is ceil(log2(HDR_BYTES+PLD_BYTES+1)) bits wide. It never wraps; it is cleared only on entry to SEND.
- Shift buffer: either shift left by 8 per transfer or index by cnt. In both cases tx_data is stable while tx_valid & ~tx_ready.
- busy = 1 in SEND and DONE, 0 in IDLE.
- ovr: set when start occurs in SEND or DONE. That message is dropped and the in-flight message is unaffected. Cleared by clr_ovr. If a set and clr_ovr occur in the same cycle, set wins.
- Header/payload inputs are sampled only in the capture cycle. Later changes do not affect the stream.

## Timing
- Reset values (async, while reset_L=0): state IDLE, ack_q=0, cnt=0, buffer=0, tx_data=0, tx_valid=0, tx_sof=0, tx_eof=0, busy=0, done=0, ovr=0.
- Reset deasserted with msg_ack already high: ack_q=0, so start fires on the first edge and the message is sent. This is intentional.
- Latency:
  - start sampled at edge N → tx_valid=1 with byte 0 and tx_sof from edge N (visible in cycle N+1).
  - With tx_ready held at 1, bytes appear back-to-back. The last transfer is in cycle N+16 (defaults). done=1 in cycle N+17. IDLE from cycle N+18.
- Minimum message-to-message spacing: start is accepted only in IDLE. An edge landing in the DONE cycle is an overrun.
- tx_ready is ignored while tx_valid=0. tx_valid never drops mid-message except by reset.
- Reset mid-message: the stream is aborted immediately. No eof or done is produced. Outputs take reset values.

## Test plan
- Basic: header=32'h1081_01FF, payload={32'h04568787, 32'hAC786425, 32'h0F986550}, tx_ready=1 → bytes 10,81,01,FF,04,56,87,87,AC,78,64,25,0F,98,65,50. sof on 10, eof on 50. done one cycle later. busy high for 17 cycles.
- Backpressure: same message, tx_ready toggled 1/0 every cycle → same 16-byte order. tx_data/sof/eof stable during stalls. 31 valid cycles.
- Held ack: msg_ack held high for 40 cycles → exactly one message sent, ovr=0.
- Overrun: second msg_ack 0→1 during byte 5 → first message completes intact and ovr=1. clr_ovr pulse → ovr=0. The second message is never sent.
- Reset mid-stream: assert reset_L=0 during byte 8 → tx_valid, busy and done go to 0 immediately. After release plus a new edge, a full message is sent starting with sof.
- Back-to-back: new edge on the first IDLE cycle after done → accepted, second stream starts the next cycle, ovr=0.
